// File: rtl/flowled_param.sv
// Parametrised running-light controller: four LED patterns, selectable step rate,
// and start/pause/resume/stop driven by synchronised, edge-detected push buttons.
module flowled_param #(
    parameter int N_LED    = 8,
    parameter int TICK_DIV = 1048576,
    parameter int CNT_W    = 21
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [1:0]       speed,
    output logic [N_LED-1:0] cled,
    output logic             running,
    output logic             step_pulse
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;

    localparam logic [CNT_W:0]   TICK    = (CNT_W+1)'(TICK_DIV);
    localparam logic [N_LED-1:0] LSB_ONE = N_LED'(1);
    localparam logic [N_LED-1:0] MSB_ONE = {1'b1, {(N_LED-1){1'b0}}};

    logic             start_p0, start_p1, start_p2;
    logic             stop_p0, stop_p1, stop_p2;
    logic             start_edge, stop_edge;
    logic [1:0]       state;
    logic [1:0]       mode_q;
    logic             dir_up;
    logic [CNT_W-1:0] div_cnt;
    logic [CNT_W-1:0] per_m1;
    logic [CNT_W:0]   shifted;
    logic [N_LED:0]   nxt;

    // Returns {direction, next pattern}; direction doubles as the fill/drain phase in mode 3.
    function automatic logic [N_LED:0] advance(input logic [1:0]       m,
                                               input logic [N_LED-1:0] cur,
                                               input logic             up);
        logic [N_LED:0] r;
        logic           fill_bit;
        r        = {up, cur};
        fill_bit = 1'b0;
        case (m)
            2'd0: r = {up, cur[N_LED-2:0], cur[N_LED-1]};
            2'd1: r = {up, cur[0], cur[N_LED-1:1]};
            2'd2: begin
                if ((up && !cur[N_LED-1]) || (!up && cur[0]))
                    r = {1'b1, cur << 1};
                else
                    r = {1'b0, cur >> 1};
            end
            default: begin
                fill_bit = up ? ~(&cur) : (cur == '0);
                r        = {fill_bit, cur[N_LED-2:0], fill_bit};
            end
        endcase
        return r;
    endfunction

    // Stage p0/p1: two-flop synchroniser; p2: delay flop for rising-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_p0 <= 1'b0;
            start_p1 <= 1'b0;
            start_p2 <= 1'b0;
            stop_p0  <= 1'b0;
            stop_p1  <= 1'b0;
            stop_p2  <= 1'b0;
        end else begin
            start_p0 <= start;
            start_p1 <= start_p0;
            start_p2 <= start_p1;
            stop_p0  <= stop;
            stop_p1  <= stop_p0;
            stop_p2  <= stop_p1;
        end
    end

    assign start_edge = start_p1 & ~start_p2;
    assign stop_edge  = stop_p1 & ~stop_p2;

    // Step period minus one, never below zero so that P bottoms out at one clock.
    always_comb begin
        shifted = TICK >> speed;
        per_m1  = '0;
        if (shifted > (CNT_W+1)'(1))
            per_m1 = CNT_W'(shifted - (CNT_W+1)'(1));
    end

    assign nxt = advance(mode_q, cled, dir_up);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            mode_q     <= 2'd0;
            dir_up     <= 1'b1;
            div_cnt    <= '0;
            cled       <= '0;
            running    <= 1'b0;
            step_pulse <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_edge && !stop_edge) begin
                        state   <= RUN;
                        running <= 1'b1;
                        mode_q  <= mode;
                        cled    <= (mode == 2'd1) ? MSB_ONE : LSB_ONE;
                        div_cnt <= '0;
                        dir_up  <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop_edge) begin
                        state   <= IDLE;
                        running <= 1'b0;
                        cled    <= '0;
                        div_cnt <= '0;
                    end else if (start_edge) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end else if (div_cnt >= per_m1) begin
                        div_cnt    <= '0;
                        cled       <= nxt[N_LED-1:0];
                        dir_up     <= nxt[N_LED];
                        step_pulse <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + CNT_W'(1);
                    end
                end
                PAUSE: begin
                    if (stop_edge) begin
                        state   <= IDLE;
                        running <= 1'b0;
                        cled    <= '0;
                        div_cnt <= '0;
                    end else if (start_edge) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    cled    <= '0;
                    div_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flowled_param.sv
// Scoreboard bench for flowled_param: expected LED frames are queued as stimulus is
// applied and compared, together with the step spacing, whenever step_pulse fires.
module tb_flowled_param;

    localparam int N  = 8;
    localparam int TD = 4;
    localparam int CW = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         stop;
    logic [1:0]   mode;
    logic [1:0]   speed;
    logic [N-1:0] cled;
    logic         running;
    logic         step_pulse;

    int           checks = 0;
    int           errors = 0;
    logic [N-1:0] exp_q[$];

    always #5 clk = ~clk;

    flowled_param #(.N_LED(N), .TICK_DIV(TD), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .speed      (speed),
        .cled       (cled),
        .running    (running),
        .step_pulse (step_pulse)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_step(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!step_pulse && n < 50);
        if (!step_pulse) check("step timeout", step_pulse, 1);
    endtask

    task automatic run_steps(input int cnt, input int per);
        int           n;
        logic [N-1:0] e;
        for (int i = 0; i < cnt; i++) begin
            wait_step(n);
            check("step period", n, per);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            check("step cled", cled, e);
        end
    endtask

    // Button press held across one rising edge, starting at the current negedge.
    task automatic press(input logic s, input logic p);
        start = s;
        stop  = p;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic idle_cycles(input int cnt);
        for (int i = 0; i < cnt; i++) @(negedge clk);
    endtask

    task automatic push_rot(input bit left, input int idx0, input int cnt);
        int idx;
        idx = idx0;
        for (int i = 0; i < cnt; i++) begin
            idx = left ? (idx + 1) % N : (idx + N - 1) % N;
            exp_q.push_back(N'(1) << idx);
        end
    endtask

    task automatic push_bounce(input int cnt);
        int pos;
        int dir;
        pos = 0;
        dir = 1;
        for (int i = 0; i < cnt; i++) begin
            pos = pos + dir;
            if (pos == N - 1 || pos == 0) dir = -dir;
            exp_q.push_back(N'(1) << pos);
        end
    endtask

    // Fill/drain cycle has 2N frames; frame 0 is the single lit LSB.
    task automatic push_fill(input int t0, input int cnt);
        int          t;
        logic [15:0] v;
        for (int i = 0; i < cnt; i++) begin
            t = (t0 + i) % (2 * N);
            if (t < N) v = (16'd1 << (t + 1)) - 16'd1;
            else       v = 16'h00FF << (t - N + 1);
            exp_q.push_back(v[N-1:0]);
        end
    endtask

    initial begin
        int           n;
        int           bad;
        logic [N-1:0] e;

        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        mode  = 2'd0;
        speed = 2'd0;
        #3 reset = 1'b0;
        idle_cycles(2);
        check("reset cled", cled, 0);
        check("reset running", running, 0);
        check("reset step_pulse", step_pulse, 0);
        reset = 1'b1;
        idle_cycles(2);

        // rotate left, P = 4
        press(1'b1, 1'b0);
        idle_cycles(2);
        check("start cled m0", cled, 8'h01);
        check("start running", running, 1);
        check("start step_pulse", step_pulse, 0);
        push_rot(1'b1, 0, 8);
        run_steps(8, 4);

        press(1'b0, 1'b1);
        idle_cycles(2);
        check("stop cled", cled, 0);
        check("stop running", running, 0);

        // bounce
        mode = 2'd2;
        press(1'b1, 1'b0);
        idle_cycles(2);
        check("start cled m2", cled, 8'h01);
        push_bounce(15);
        run_steps(15, 4);
        press(1'b0, 1'b1);
        idle_cycles(2);
        check("stop cled m2", cled, 0);

        // fill/drain, with mode changed after the start has latched it
        mode = 2'd3;
        press(1'b1, 1'b0);
        idle_cycles(2);
        check("start cled m3", cled, 8'h01);
        mode = 2'd0;
        push_fill(1, 16);
        run_steps(16, 4);

        // pause two clocks into the period; divider is frozen at 2
        press(1'b1, 1'b0);
        idle_cycles(2);
        check("pause running", running, 0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (step_pulse || cled !== 8'h01 || running) bad++;
        end
        check("pause frozen", bad, 0);
        push_fill(1, 1);
        press(1'b1, 1'b0);
        wait_step(n);
        check("resume period", n, 4);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("resume cled", cled, e);
        check("resume running", running, 1);
        push_fill(2, 2);
        run_steps(2, 4);

        // simultaneous start and stop: stop wins
        press(1'b1, 1'b1);
        idle_cycles(2);
        check("both cled", cled, 0);
        check("both running", running, 0);
        press(1'b0, 1'b1);
        idle_cycles(3);
        check("idle stop running", running, 0);
        check("idle stop cled", cled, 0);

        // P = 1 at speed 2 and speed 3, rotate right
        speed = 2'd2;
        mode  = 2'd1;
        press(1'b1, 1'b0);
        idle_cycles(2);
        check("start cled m1", cled, 8'h80);
        push_rot(1'b0, 7, 8);
        run_steps(8, 1);
        speed = 2'd3;
        push_rot(1'b0, 7, 1);
        run_steps(1, 1);

        // asynchronous reset between clock edges
        speed = 2'd0;
        #2 reset = 1'b0;
        #1;
        check("async rst cled", cled, 0);
        check("async rst running", running, 0);
        check("async rst step_pulse", step_pulse, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (cled !== '0 || running || step_pulse) bad++;
        end
        check("post reset idle", bad, 0);
        check("queue empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/flowled_param.md
Name: flowled_param

Overview:
Parametrised running-light controller that drives an N-bit LED bank. It supersedes the fixed 8-LED flowing light with four selectable patterns, a run-time speed select, and pause/resume. A single clock domain handles everything, with synchronised, edge-detected start/stop push-button inputs. It sits between the board buttons/switches and the LED pins of the lab top level.

Parameters:
N_LED, 8, number of LEDs driven (minimum 2).
TICK_DIV, 1048576, clocks per pattern step at speed 0 (minimum 1).
CNT_W, 21, width of the step divider counter; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  raw push button, asynchronous; rising edge = start / pause / resume.
stop  input  1  raw push button, asynchronous; rising edge = stop and blank.
mode  input  2  pattern select: 0 rotate-left, 1 rotate-right, 2 bounce, 3 fill/drain.
speed  input  2  step-rate select; step period P = max(1, TICK_DIV >> speed) clocks.
cled  output  N_LED  LED drive, 1 = lit.
running  output  1  high while in RUN.
step_pulse  output  1  one-cycle pulse on every cycle that cled advances.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, cled=0, running=0, step_pulse=0, divider=0, direction=up, synchronisers=0.
- start/stop: each passes through a 2-FF synchroniser plus a delay FF; edge = sync & ~delayed.
- Latency: a pin sampled high on edge k gives an internal edge active in the cycle after edge k+1. The resulting state/cled update lands on edge k+2.
- States:
  - IDLE: cled=0. start edge -> RUN; latch mode into mode_q; load initial pattern; divider=0; direction=up.
  - RUN: start edge -> PAUSE. stop edge -> IDLE.
  - PAUSE: cled and divider frozen. start edge -> RUN, continuing from the frozen divider value. stop edge -> IDLE.
  - start and stop edges in the same cycle: stop wins, next state is IDLE.
  - stop edge in IDLE: no effect.
- Initial patterns: mode 0, 2, 3: cled = 1 at bit 0. Mode 1: cled = 1 at bit N_LED-1.
- mode is sampled only on the IDLE->RUN transition; changes during RUN/PAUSE are ignored until the next start from IDLE.
- Divider, in RUN only:
  - Counts 0..P-1; on the cycle divider==P-1 (or divider >= P-1 after a speed change) it wraps to 0 and a step occurs on that edge.
  - speed is sampled every cycle.
  - P=1 means a step every clock.
- Steps (cled update and step_pulse=1 in the same cycle):
  - mode 0: rotate left; bit N_LED-1 wraps to bit 0.
  - mode 1: rotate right; bit 0 wraps to bit N_LED-1.
  - mode 2 (bounce): single lit bit moves up while direction=up. On reaching bit N_LED-1 the direction flips to down, so the next step goes to N_LED-2; symmetric at bit 0. End bits are lit exactly one step per pass.
  - mode 3 (fill/drain): while filling, cled = {cled[N-2:0],1'b1} until all ones. The next step starts draining: cled = {cled[N-2:0],1'b0} until all zero. The next step restarts filling with bit 0 = 1. The all-zero state lasts exactly one step.
- running is a registered output equal to (state==RUN).
- step_pulse is 0 in IDLE and PAUSE.
- Reset asserted mid-run immediately clears all outputs; after release the block waits in IDLE for a new start edge.

Test Plan:
- N_LED=8, TICK_DIV=4, speed=0, mode=0; pulse start -> 2 clocks later cled=00000001, running=1. Then cled=00000010, 00000100 ... 10000000, 00000001, one step per 4 clocks, with step_pulse each step.
- mode=2, speed=0 -> sequence 01,02,04,...,80,40,20,...,01,02. 0x80 and 0x01 each appear for a single step per pass.
- mode=3 -> 01,03,07,...,FF,FE,FC,...,80,00,01. Change mode to 0 mid-run -> pattern unchanged.
- RUN, start pulse -> PAUSE: cled frozen ≥20 clocks, running=0, no step_pulse. Second start -> first step occurs after the remaining divider count, not a full period.
- Assert start and stop edges in the same cycle during RUN -> IDLE, cled=00. Set speed=2 (P=1) then start -> step every clock.
- Drop reset for 1 clock mid-run (async, between clk edges) -> cled=00, running=0 immediately. After release, no activity until a new start edge.
